// File: rtl/playbus_responder.sv
// playbus_responder
// Bus-side responder for the PlayBus. Models the constant ROM, a 16 x 8 RAM,
// the switch buffer and the LED latch, resolves the shared data bus as a
// wired-AND with pull-ups, counts completed RAM write strobes and keeps
// sticky protocol-error flags.
//
// Ports
//   CK2HZ        in   system clock, all state updates on the rising edge
//   CLR          in   synchronous active-high reset
//   ADD[3:0]     in   bus address
//   n_ROMO       in   ROM output enable, active low
//   n_RAMO       in   RAM output enable, active low
//   n_RAMW       in   RAM write strobe, active low
//   n_SWBEN      in   switch buffer enable, active low
//   LEDLTCH      in   LED latch strobe, active high (rising level captures)
//   SW[7:0]      in   switch values
//   DATA[7:0]    out  resolved bus value (combinational)
//   LEDS[7:0]    out  LED latch contents
//   WRCOUNT[7:0] out  completed RAM write strobes, saturating at 8'hFF
//   ERR_CONTEND  out  sticky: two or more bus sources enabled together
//   ERR_FLOAT    out  sticky: write or capture with the bus undriven
//   ERR_RW       out  sticky: RAM output enable and write strobe both low
//   ERR_ADDR     out  sticky: address moved during a RAM write strobe
module playbus_responder (
  input  logic       CK2HZ,
  input  logic       CLR,
  input  logic [3:0] ADD,
  input  logic       n_ROMO,
  input  logic       n_RAMO,
  input  logic       n_RAMW,
  input  logic       n_SWBEN,
  input  logic       LEDLTCH,
  input  logic [7:0] SW,
  output logic [7:0] DATA,
  output logic [7:0] LEDS,
  output logic [7:0] WRCOUNT,
  output logic       ERR_CONTEND,
  output logic       ERR_FLOAT,
  output logic       ERR_RW,
  output logic       ERR_ADDR
);

  logic [7:0] ram [16];
  logic [7:0] rom_q;
  logic       prev_nramw;
  logic       prev_ledltch;
  logic [3:0] strobe_add;

  logic contend;
  logic none_en;
  logic ram_wr;
  logic led_cap;
  logic strobe_start;
  logic strobe_done;
  logic addr_moved;

  assign rom_q = {~ADD, ADD};

  // Wired-AND bus: every enabled source can only pull bits low.
  always_comb begin
    DATA = '1;
    if (!n_ROMO)  DATA = DATA & rom_q;
    if (!n_RAMO)  DATA = DATA & ram[ADD];
    if (!n_SWBEN) DATA = DATA & SW;
  end

  assign contend      = (~n_ROMO & ~n_RAMO) | (~n_ROMO & ~n_SWBEN) | (~n_RAMO & ~n_SWBEN);
  assign none_en      = n_ROMO & n_RAMO & n_SWBEN;
  assign ram_wr       = ~n_RAMW & n_RAMO;
  assign led_cap      = LEDLTCH & ~prev_ledltch;
  assign strobe_start = prev_nramw & ~n_RAMW;
  assign strobe_done  = ~prev_nramw & n_RAMW;
  assign addr_moved   = ~prev_nramw & ~n_RAMW & (ADD != strobe_add);

  always_ff @(posedge CK2HZ) begin
    if (CLR) begin
      ram          <= '{default: '0};
      LEDS         <= '0;
      WRCOUNT      <= '0;
      ERR_CONTEND  <= 1'b0;
      ERR_FLOAT    <= 1'b0;
      ERR_RW       <= 1'b0;
      ERR_ADDR     <= 1'b0;
      prev_nramw   <= 1'b1;
      prev_ledltch <= 1'b0;
      strobe_add   <= '0;
    end else begin
      prev_nramw   <= n_RAMW;
      prev_ledltch <= LEDLTCH;

      // Writes always use the current address; the registered one only
      // detects a strobe whose address wandered.
      if (ram_wr)       ram[ADD]   <= DATA;
      if (strobe_start) strobe_add <= ADD;
      if (led_cap)      LEDS       <= DATA;

      if (strobe_done && WRCOUNT != 8'hFF) WRCOUNT <= WRCOUNT + 8'd1;

      if (contend)                          ERR_CONTEND <= 1'b1;
      if ((ram_wr || led_cap) && none_en)   ERR_FLOAT   <= 1'b1;
      if (~n_RAMO & ~n_RAMW)                ERR_RW      <= 1'b1;
      if (addr_moved)                       ERR_ADDR    <= 1'b1;
    end
  end

endmodule
